// File: rtl/dc_exp_unit_pkg.sv
// Shared constants for the data-cache exception unit: cause codes,
// TLB flag bit positions, FSM state encoding and a width helper.
package dc_exp_pkg;

  // Exception cause codes presented to the ISR sequencer
  typedef logic [1:0] cause_t;
  localparam cause_t CAUSE_NONE = 2'b00;
  localparam cause_t CAUSE_PF   = 2'b01;
  localparam cause_t CAUSE_PROT = 2'b10;

  // TLB flag vector layout: {valid, present, rw}
  localparam int FLAG_W       = 3;
  localparam int FLAG_RW      = 0;
  localparam int FLAG_PRESENT = 1;
  localparam int FLAG_VALID   = 2;

  // Capture FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Channel-index width; a single channel still gets one bit
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dc_exp_unit_if.sv
// Exception handshake between the checker (master) and the ISR
// sequencer (slave): pending exception fields, ack and stall.
interface dc_exp_unit_if #(
  parameter int CH_W = 1
);
  logic            exc_valid;
  logic [1:0]      exc_cause;
  logic [CH_W-1:0] exc_ch;
  logic [31:0]     exc_addr;
  logic            exc_ack;
  logic            exc_stall;

  modport master (
    output exc_valid, exc_cause, exc_ch, exc_addr, exc_stall,
    input  exc_ack
  );

  modport slave (
    input  exc_valid, exc_cause, exc_ch, exc_addr, exc_stall,
    output exc_ack
  );
endinterface

// File: rtl/dc_exp_unit_tlb_lookup.sv
// Fully associative TLB match for one channel. An entry matches when it
// is valid and present and its vpn equals the request; lowest index wins.
module dc_tlb_lookup
  import dc_exp_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int VPN_W       = 20
) (
  input  logic [VPN_W-1:0]              vpn,
  input  logic [TLB_ENTRIES*VPN_W-1:0]  tlb_vpn,
  input  logic [TLB_ENTRIES*VPN_W-1:0]  tlb_ppn,
  input  logic [TLB_ENTRIES*FLAG_W-1:0] tlb_flags,
  output logic                          hit,
  output logic [VPN_W-1:0]              ppn,
  output logic                          rw
);

  logic [TLB_ENTRIES-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < TLB_ENTRIES; gi++) begin : g_match
      assign match[gi] = tlb_flags[gi*FLAG_W + FLAG_VALID]
                       & tlb_flags[gi*FLAG_W + FLAG_PRESENT]
                       & (tlb_vpn[gi*VPN_W +: VPN_W] == vpn);
    end
  endgenerate

  // Priority select: scan high to low so the lowest matching index lands last
  always_comb begin
    hit = 1'b0;
    ppn = '0;
    rw  = 1'b0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        ppn = tlb_ppn[i*VPN_W +: VPN_W];
        rw  = tlb_flags[i*FLAG_W + FLAG_RW];
      end
    end
  end

endmodule

// File: rtl/dc_exp_unit.sv
// Data-cache exception unit: per-channel TLB translation, page-fault and
// segment-limit protection checks, registered flags, and a one-deep
// exception hold register handed to the ISR sequencer via valid/ack.
module dc_exp_unit
  import dc_exp_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int TLB_ENTRIES = 8,
  parameter int VPN_W       = 20,
  parameter int RD_OFS_BITS = 5,
  parameter int WR_OFS_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH-1:0]              ch_is_wr,
  input  logic [NUM_CH*32-1:0]           ch_addr,
  input  logic [NUM_CH*32-1:0]           ch_offset,
  input  logic [NUM_CH*32-1:0]           ch_limit,
  input  logic                           isr,
  input  logic                           tlb_wr_en,
  input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_wr_idx,
  input  logic [VPN_W-1:0]               tlb_wr_vpn,
  input  logic [VPN_W-1:0]               tlb_wr_ppn,
  input  logic [FLAG_W-1:0]              tlb_wr_flags,
  output logic [NUM_CH*VPN_W-1:0]        ch_ppn,
  output logic [NUM_CH-1:0]              ch_page_fault,
  output logic [NUM_CH-1:0]              ch_prot_exp,
  output logic                           dc_exp,
  dc_exp_unit_if.master                  exc_if
);

  localparam int CH_W = ch_idx_width(NUM_CH);

  // TLB storage; a CAM needs every entry visible at once, so these are flops
  logic [VPN_W-1:0]  tlb_vpn_reg   [TLB_ENTRIES];
  logic [VPN_W-1:0]  tlb_ppn_reg   [TLB_ENTRIES];
  logic [FLAG_W-1:0] tlb_flags_reg [TLB_ENTRIES];

  logic [TLB_ENTRIES*VPN_W-1:0]  tlb_vpn_flat;
  logic [TLB_ENTRIES*VPN_W-1:0]  tlb_ppn_flat;
  logic [TLB_ENTRIES*FLAG_W-1:0] tlb_flags_flat;

  // Per-channel combinational results
  logic [NUM_CH-1:0]       pf_next;
  logic [NUM_CH-1:0]       prot_next;
  logic [NUM_CH*VPN_W-1:0] ppn_next;

  // Registered channel outputs
  logic [NUM_CH-1:0]       pf_reg;
  logic [NUM_CH-1:0]       prot_reg;
  logic [NUM_CH*VPN_W-1:0] ppn_reg;
  logic                    dc_exp_reg;

  // Capture selection and hold register
  logic            cap_hit;
  logic [CH_W-1:0] cap_ch;
  cause_t          cap_cause;
  logic [31:0]     cap_addr;

  logic [0:0]      state_reg;
  logic            exc_valid_reg;
  cause_t          exc_cause_reg;
  logic [CH_W-1:0] exc_ch_reg;
  logic [31:0]     exc_addr_reg;

  // TLB load: lookups this cycle still see the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_vpn_reg[i]   <= '0;
        tlb_ppn_reg[i]   <= '0;
        tlb_flags_reg[i] <= '0;
      end
    end else if (tlb_wr_en) begin
      tlb_vpn_reg[tlb_wr_idx]   <= tlb_wr_vpn;
      tlb_ppn_reg[tlb_wr_idx]   <= tlb_wr_ppn;
      tlb_flags_reg[tlb_wr_idx] <= tlb_wr_flags;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TLB_ENTRIES; gi++) begin : g_flat
      assign tlb_vpn_flat[gi*VPN_W +: VPN_W]     = tlb_vpn_reg[gi];
      assign tlb_ppn_flat[gi*VPN_W +: VPN_W]     = tlb_ppn_reg[gi];
      assign tlb_flags_flat[gi*FLAG_W +: FLAG_W] = tlb_flags_reg[gi];
    end

    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [31:0]      addr;
      logic [31:0]      offset;
      logic [31:0]      limit;
      logic [31:0]      rd_end;
      logic [31:0]      wr_end;
      logic             hit;
      logic             rw;
      logic [VPN_W-1:0] ppn;
      logic             rd_cross;
      logic             wr_cross;
      logic             unused_ofs;

      assign addr   = ch_addr[32*gi +: 32];
      assign offset = ch_offset[32*gi +: 32];
      assign limit  = ch_limit[32*gi +: 32];

      dc_tlb_lookup #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .VPN_W       (VPN_W)
      ) u_lookup (
        .vpn       (addr[31 -: VPN_W]),
        .tlb_vpn   (tlb_vpn_flat),
        .tlb_ppn   (tlb_ppn_flat),
        .tlb_flags (tlb_flags_flat),
        .hit       (hit),
        .ppn       (ppn),
        .rw        (rw)
      );

      // Limit checks use the last byte the access may touch in its span
      assign rd_end   = {offset[31:RD_OFS_BITS], {RD_OFS_BITS{1'b1}}};
      assign wr_end   = {offset[31:WR_OFS_BITS], {WR_OFS_BITS{1'b1}}};
      assign rd_cross = rd_end > limit;
      assign wr_cross = wr_end > limit;

      // Low offset bits are replaced by ones and never looked at
      assign unused_ofs = ^{offset[RD_OFS_BITS-1:0], offset[WR_OFS_BITS-1:0]};

      assign pf_next[gi]   = ch_valid[gi] & ~hit;
      assign prot_next[gi] = ch_valid[gi] & ~isr &
                             (ch_is_wr[gi] ? (wr_cross | (hit & ~rw)) : rd_cross);
      assign ppn_next[gi*VPN_W +: VPN_W] = ppn;
    end
  endgenerate

  // Pick the lowest faulting channel; page fault outranks protection
  always_comb begin
    cap_hit   = 1'b0;
    cap_ch    = '0;
    cap_cause = CAUSE_NONE;
    cap_addr  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pf_next[i] | prot_next[i]) begin
        cap_hit   = 1'b1;
        cap_ch    = CH_W'(i);
        cap_cause = pf_next[i] ? CAUSE_PF : CAUSE_PROT;
        cap_addr  = ch_addr[32*i +: 32];
      end
    end
  end

  // Per-channel flags and translations, registered every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_reg     <= '0;
      prot_reg   <= '0;
      ppn_reg    <= '0;
      dc_exp_reg <= 1'b0;
    end else begin
      pf_reg     <= pf_next;
      prot_reg   <= prot_next;
      ppn_reg    <= ppn_next;
      dc_exp_reg <= |{pf_next, prot_next};
    end
  end

  // Capture FSM: latch one exception, hold it until the sequencer acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      exc_valid_reg <= 1'b0;
      exc_cause_reg <= CAUSE_NONE;
      exc_ch_reg    <= '0;
      exc_addr_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cap_hit) begin
            state_reg     <= ST_PEND;
            exc_valid_reg <= 1'b1;
            exc_cause_reg <= cap_cause;
            exc_ch_reg    <= cap_ch;
            exc_addr_reg  <= cap_addr;
          end
        end
        ST_PEND: begin
          // A fault arriving with the ack is dropped; stall forces a replay
          if (exc_if.exc_ack) begin
            state_reg     <= ST_IDLE;
            exc_valid_reg <= 1'b0;
            exc_cause_reg <= CAUSE_NONE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          exc_valid_reg <= 1'b0;
          exc_cause_reg <= CAUSE_NONE;
        end
      endcase
    end
  end

  assign ch_page_fault    = pf_reg;
  assign ch_prot_exp      = prot_reg;
  assign ch_ppn           = ppn_reg;
  assign dc_exp           = dc_exp_reg;
  assign exc_if.exc_valid = exc_valid_reg;
  assign exc_if.exc_cause = exc_cause_reg;
  assign exc_if.exc_ch    = exc_ch_reg;
  assign exc_if.exc_addr  = exc_addr_reg;
  assign exc_if.exc_stall = exc_valid_reg | cap_hit;

endmodule

// File: tb/tb_dc_exp_unit.sv
// Directed bench for dc_exp_unit: TLB hit/miss, limit checks, isr
// suppression, channel priority, PEND hold/ack and async reset.
module tb_dc_exp_unit;
  import dc_exp_pkg::*;

  localparam int NUM_CH = 2;
  localparam int VPN_W  = 20;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH-1:0]       ch_is_wr;
  logic [NUM_CH*32-1:0]    ch_addr;
  logic [NUM_CH*32-1:0]    ch_offset;
  logic [NUM_CH*32-1:0]    ch_limit;
  logic                    isr;
  logic                    tlb_wr_en;
  logic [2:0]              tlb_wr_idx;
  logic [VPN_W-1:0]        tlb_wr_vpn;
  logic [VPN_W-1:0]        tlb_wr_ppn;
  logic [2:0]              tlb_wr_flags;
  logic [NUM_CH*VPN_W-1:0] ch_ppn;
  logic [NUM_CH-1:0]       ch_page_fault;
  logic [NUM_CH-1:0]       ch_prot_exp;
  logic                    dc_exp;

  int checks   = 0;
  int failures = 0;

  dc_exp_unit_if #(.CH_W(1)) exc_if ();

  dc_exp_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_valid      (ch_valid),
    .ch_is_wr      (ch_is_wr),
    .ch_addr       (ch_addr),
    .ch_offset     (ch_offset),
    .ch_limit      (ch_limit),
    .isr           (isr),
    .tlb_wr_en     (tlb_wr_en),
    .tlb_wr_idx    (tlb_wr_idx),
    .tlb_wr_vpn    (tlb_wr_vpn),
    .tlb_wr_ppn    (tlb_wr_ppn),
    .tlb_wr_flags  (tlb_wr_flags),
    .ch_ppn        (ch_ppn),
    .ch_page_fault (ch_page_fault),
    .ch_prot_exp   (ch_prot_exp),
    .dc_exp        (dc_exp),
    .exc_if        (exc_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick(input string what);
    @(posedge clk);
    #1;
    $display("step %s: pf=%b prot=%b dc_exp=%b exc_valid=%b cause=%b ch=%0d addr=%h",
             what, ch_page_fault, ch_prot_exp, dc_exp, exc_if.exc_valid,
             exc_if.exc_cause, exc_if.exc_ch, exc_if.exc_addr);
  endtask

  task automatic set_ch(input int c, input logic v, input logic wr, input logic [31:0] a,
                        input logic [31:0] ofs, input logic [31:0] lim);
    ch_valid[c]          = v;
    ch_is_wr[c]          = wr;
    ch_addr[32*c +: 32]  = a;
    ch_offset[32*c +: 32] = ofs;
    ch_limit[32*c +: 32] = lim;
  endtask

  task automatic tlb_load(input logic [2:0] idx, input logic [19:0] vpn,
                          input logic [19:0] ppn, input logic [2:0] flags);
    tlb_wr_en    = 1'b1;
    tlb_wr_idx   = idx;
    tlb_wr_vpn   = vpn;
    tlb_wr_ppn   = ppn;
    tlb_wr_flags = flags;
  endtask

  initial begin
    rst_n = 1'b0;
    ch_valid = '0; ch_is_wr = '0; ch_addr = '0; ch_offset = '0; ch_limit = '0;
    isr = 1'b0; tlb_wr_en = 1'b0; tlb_wr_idx = '0; tlb_wr_vpn = '0;
    tlb_wr_ppn = '0; tlb_wr_flags = '0; exc_if.exc_ack = 1'b0;

    // Reset state
    tick("reset");
    tick("reset");
    chk("rst_pf", 64'(ch_page_fault), 64'h0);
    chk("rst_prot", 64'(ch_prot_exp), 64'h0);
    chk("rst_dc_exp", 64'(dc_exp), 64'h0);
    chk("rst_exc_valid", 64'(exc_if.exc_valid), 64'h0);
    chk("rst_ppn", 64'(ch_ppn), 64'h0);
    chk("rst_stall", 64'(exc_if.exc_stall), 64'h0);
    rst_n = 1'b1;

    // Empty TLB: read miss on ch0 is a page fault
    set_ch(0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF);
    #1 chk("pf_stall_comb", 64'(exc_if.exc_stall), 64'h1);
    tick("pf_empty_tlb");
    chk("pf_flag", 64'(ch_page_fault), 64'h1);
    chk("pf_prot", 64'(ch_prot_exp), 64'h0);
    chk("pf_dc_exp", 64'(dc_exp), 64'h1);
    chk("pf_valid", 64'(exc_if.exc_valid), 64'h1);
    chk("pf_cause", 64'(exc_if.exc_cause), 64'h1);
    chk("pf_ch", 64'(exc_if.exc_ch), 64'h0);
    chk("pf_addr", 64'(exc_if.exc_addr), 64'h1234);

    // Ack clears valid/cause, addr and ch retained
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    exc_if.exc_ack = 1'b1;
    tick("ack1");
    exc_if.exc_ack = 1'b0;
    chk("ack1_valid", 64'(exc_if.exc_valid), 64'h0);
    chk("ack1_cause", 64'(exc_if.exc_cause), 64'h0);
    chk("ack1_addr_kept", 64'(exc_if.exc_addr), 64'h1234);

    // Load idx3 vpn 1 -> ppn ABC, rw; in-limit read
    tlb_load(3'd3, 20'h00001, 20'h00ABC, 3'b111);
    tick("tlb_load3");
    tlb_wr_en = 1'b0;
    set_ch(0, 1'b1, 1'b0, 32'h0000_1FF0, 32'h0000_0FE0, 32'h0000_0FFF);
    tick("read_hit_in_limit");
    chk("hit_ppn0", 64'(ch_ppn[19:0]), 64'hABC);
    chk("hit_pf", 64'(ch_page_fault), 64'h0);
    chk("hit_prot", 64'(ch_prot_exp), 64'h0);
    chk("hit_valid", 64'(exc_if.exc_valid), 64'h0);

    // Read end 0x0FFF beyond limit 0x0FF0
    set_ch(0, 1'b1, 1'b0, 32'h0000_1FF0, 32'h0000_0FE0, 32'h0000_0FF0);
    tick("read_over_limit");
    chk("rdx_prot", 64'(ch_prot_exp), 64'h1);
    chk("rdx_pf", 64'(ch_page_fault), 64'h0);
    chk("rdx_cause", 64'(exc_if.exc_cause), 64'h2);
    chk("rdx_addr", 64'(exc_if.exc_addr), 64'h1FF0);
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    exc_if.exc_ack = 1'b1;
    tick("ack2");
    exc_if.exc_ack = 1'b0;
    chk("ack2_valid", 64'(exc_if.exc_valid), 64'h0);

    // Same access under isr: protection suppressed
    isr = 1'b1;
    set_ch(0, 1'b1, 1'b0, 32'h0000_1FF0, 32'h0000_0FE0, 32'h0000_0FF0);
    tick("read_over_limit_isr");
    chk("isr_prot", 64'(ch_prot_exp), 64'h0);
    chk("isr_dc_exp", 64'(dc_exp), 64'h0);
    chk("isr_valid", 64'(exc_if.exc_valid), 64'h0);
    isr = 1'b0;
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Read-only page (vpn 2) written on ch1
    tlb_load(3'd4, 20'h00002, 20'h00DEF, 3'b110);
    tick("tlb_load4");
    tlb_wr_en = 1'b0;
    set_ch(1, 1'b1, 1'b1, 32'h0000_2000, 32'h0, 32'hFFFF_FFFF);
    tick("write_ro_ch1");
    chk("ro_prot", 64'(ch_prot_exp), 64'h2);
    chk("ro_pf", 64'(ch_page_fault), 64'h0);
    chk("ro_ppn1", 64'(ch_ppn[39:20]), 64'hDEF);
    chk("ro_ch", 64'(exc_if.exc_ch), 64'h1);
    chk("ro_cause", 64'(exc_if.exc_cause), 64'h2);
    chk("ro_addr", 64'(exc_if.exc_addr), 64'h2000);

    // Ack while the fault persists: cleared, not recaptured
    exc_if.exc_ack = 1'b1;
    tick("ack_with_fault");
    chk("ackf_valid", 64'(exc_if.exc_valid), 64'h0);
    chk("ackf_cause", 64'(exc_if.exc_cause), 64'h0);
    chk("ackf_ch_kept", 64'(exc_if.exc_ch), 64'h1);
    exc_if.exc_ack = 1'b0;
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick("idle");

    // ch0 page fault and ch1 protection together: ch0 wins with PF
    set_ch(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 32'hFFFF_FFFF);
    set_ch(1, 1'b1, 1'b1, 32'h0000_2000, 32'h0, 32'hFFFF_FFFF);
    tick("dual_fault");
    chk("dual_pf", 64'(ch_page_fault), 64'h1);
    chk("dual_prot", 64'(ch_prot_exp), 64'h2);
    chk("dual_ch", 64'(exc_if.exc_ch), 64'h0);
    chk("dual_cause", 64'(exc_if.exc_cause), 64'h1);
    chk("dual_addr", 64'(exc_if.exc_addr), 64'h5000);

    // Held in PEND while new faults keep arriving
    set_ch(0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 32'hFFFF_FFFF);
    for (int k = 0; k < 5; k++) begin
      #1 chk("hold_stall", 64'(exc_if.exc_stall), 64'h1);
      tick("pend_hold");
      chk("hold_valid", 64'(exc_if.exc_valid), 64'h1);
      chk("hold_addr", 64'(exc_if.exc_addr), 64'h5000);
      chk("hold_ch", 64'(exc_if.exc_ch), 64'h0);
      chk("hold_cause", 64'(exc_if.exc_cause), 64'h1);
    end
    exc_if.exc_ack = 1'b1;
    tick("ack_hold");
    chk("ackh_valid", 64'(exc_if.exc_valid), 64'h0);
    exc_if.exc_ack = 1'b0;
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick("idle");

    // TLB write and lookup of vpn 3 in one cycle: miss, then hit
    tlb_load(3'd5, 20'h00003, 20'h00123, 3'b111);
    set_ch(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hFFFF_FFFF);
    tick("tlb_write_same_cycle");
    tlb_wr_en = 1'b0;
    chk("wsame_pf", 64'(ch_page_fault), 64'h1);
    chk("wsame_addr", 64'(exc_if.exc_addr), 64'h3000);
    exc_if.exc_ack = 1'b1;
    tick("tlb_next_cycle");
    exc_if.exc_ack = 1'b0;
    chk("wnext_pf", 64'(ch_page_fault), 64'h0);
    chk("wnext_ppn0", 64'(ch_ppn[19:0]), 64'h123);
    chk("wnext_valid", 64'(exc_if.exc_valid), 64'h0);

    // Async reset during PEND
    set_ch(0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 32'hFFFF_FFFF);
    tick("pend_before_reset");
    chk("prer_valid", 64'(exc_if.exc_valid), 64'h1);
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    $display("step async_reset: exc_valid=%b", exc_if.exc_valid);
    chk("areset_valid", 64'(exc_if.exc_valid), 64'h0);
    chk("areset_addr", 64'(exc_if.exc_addr), 64'h0);
    chk("areset_pf", 64'(ch_page_fault), 64'h0);
    chk("areset_dc_exp", 64'(dc_exp), 64'h0);
    tick("in_reset");
    rst_n = 1'b1;

    // TLB was wiped: the formerly mapped page now faults
    set_ch(0, 1'b1, 1'b0, 32'h0000_1FF0, 32'h0, 32'hFFFF_FFFF);
    tick("after_reset_lookup");
    chk("wiped_pf", 64'(ch_page_fault), 64'h1);
    chk("wiped_ppn0", 64'(ch_ppn[19:0]), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
